// File: rtl/reorder_buffer.sv
// ==========================================================================
// reorder_buffer: in-order retirement buffer with CDB capture and taken-branch flush
// Revision: 1.0
// ==========================================================================
`default_nettype none

module reorder_buffer #(
  parameter int DEPTH      = 16,
  parameter int TAG_W      = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_en_i,
  input  logic [4:0]            alloc_rd_i,
  input  logic                  alloc_reg_write_i,
  input  logic                  alloc_store_i,
  input  logic                  alloc_branch_i,
  output logic [TAG_W-1:0]      alloc_tag_o,
  output logic                  rob_full_o,
  output logic                  rob_empty_o,
  output logic [TAG_W:0]        rob_count_o,
  input  logic                  cdb_valid_i,
  input  logic [TAG_W-1:0]      cdb_tag_i,
  input  logic [DATA_WIDTH-1:0] cdb_data_i,
  input  logic                  cdb_branch_i,
  input  logic                  cdb_branch_taken_i,
  input  logic                  store_commit_ready_i,
  output logic                  commit_valid_o,
  output logic [TAG_W-1:0]      commit_tag_o,
  output logic [4:0]            commit_rd_o,
  output logic [DATA_WIDTH-1:0] commit_data_o,
  output logic                  commit_reg_write_o,
  output logic                  commit_store_o,
  output logic                  flush_o
);

  localparam logic [TAG_W:0] c_FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]      busy_q, done_q, reg_write_q, store_q, branch_q, taken_q;
  logic [4:0]            rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]        count_q, count_d;

  logic                  commit_valid_q, commit_reg_write_q, commit_store_q, flush_q;
  logic [TAG_W-1:0]      commit_tag_q;
  logic [4:0]            commit_rd_q;
  logic [DATA_WIDTH-1:0] commit_data_q;

  logic w_full, w_alloc, w_commit, w_flush, w_capture;

  // Full comes from the registered count, so a full buffer refuses allocation
  // even in the cycle it retires an entry.
  assign w_full    = (count_q == c_FULL_COUNT);
  assign w_alloc   = alloc_en_i & ~w_full;
  assign w_commit  = busy_q[head_q] & done_q[head_q] &
                     (~store_q[head_q] | store_commit_ready_i);
  assign w_flush   = w_commit & branch_q[head_q] & taken_q[head_q];
  assign w_capture = cdb_valid_i & busy_q[cdb_tag_i] & ~done_q[cdb_tag_i];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_commit) head_d = head_q + TAG_W'(1);
      if (w_alloc)  tail_d = tail_q + TAG_W'(1);
      if (w_alloc && !w_commit)      count_d = count_q + (TAG_W+1)'(1);
      else if (!w_alloc && w_commit) count_d = count_q - (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      done_q      <= '0;
      reg_write_q <= '0;
      store_q     <= '0;
      branch_q    <= '0;
      taken_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (w_flush) begin
        busy_q <= '0;
        done_q <= '0;
      end else begin
        // Capture, allocation and retirement never touch the same entry:
        // the tail slot is idle and the retiring head is already done.
        if (w_capture) begin
          done_q[cdb_tag_i]  <= 1'b1;
          data_q[cdb_tag_i]  <= cdb_data_i;
          taken_q[cdb_tag_i] <= cdb_branch_i & cdb_branch_taken_i;
        end
        if (w_alloc) begin
          busy_q[tail_q]      <= 1'b1;
          done_q[tail_q]      <= 1'b0;
          taken_q[tail_q]     <= 1'b0;
          rd_q[tail_q]        <= alloc_rd_i;
          reg_write_q[tail_q] <= alloc_reg_write_i;
          store_q[tail_q]     <= alloc_store_i;
          branch_q[tail_q]    <= alloc_branch_i;
        end
        if (w_commit) begin
          busy_q[head_q] <= 1'b0;
          done_q[head_q] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      commit_valid_q     <= 1'b0;
      commit_reg_write_q <= 1'b0;
      commit_store_q     <= 1'b0;
      flush_q            <= 1'b0;
      commit_tag_q       <= '0;
      commit_rd_q        <= '0;
      commit_data_q      <= '0;
    end else begin
      commit_valid_q     <= w_commit;
      commit_reg_write_q <= w_commit & reg_write_q[head_q];
      commit_store_q     <= w_commit & store_q[head_q];
      flush_q            <= w_flush;
      if (w_commit) begin
        commit_tag_q  <= head_q;
        commit_rd_q   <= rd_q[head_q];
        commit_data_q <= data_q[head_q];
      end
    end
  end

  assign alloc_tag_o        = tail_q;
  assign rob_full_o         = w_full;
  assign rob_empty_o        = (count_q == '0);
  assign rob_count_o        = count_q;
  assign commit_valid_o     = commit_valid_q;
  assign commit_tag_o       = commit_tag_q;
  assign commit_rd_o        = commit_rd_q;
  assign commit_data_o      = commit_data_q;
  assign commit_reg_write_o = commit_reg_write_q;
  assign commit_store_o     = commit_store_q;
  assign flush_o            = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ==========================================================================
// tb_reorder_buffer: vector table, corner sequences and random run against a queue model
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_reorder_buffer;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        alloc_en_i, alloc_reg_write_i, alloc_store_i, alloc_branch_i;
  logic [4:0]  alloc_rd_i;
  logic [3:0]  alloc_tag_o;
  logic        rob_full_o, rob_empty_o;
  logic [4:0]  rob_count_o;
  logic        cdb_valid_i, cdb_branch_i, cdb_branch_taken_i, store_commit_ready_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_data_i;
  logic        commit_valid_o, commit_reg_write_o, commit_store_o, flush_o;
  logic [3:0]  commit_tag_o;
  logic [4:0]  commit_rd_o;
  logic [31:0] commit_data_o;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(4), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_en_i(alloc_en_i), .alloc_rd_i(alloc_rd_i), .alloc_reg_write_i(alloc_reg_write_i),
    .alloc_store_i(alloc_store_i), .alloc_branch_i(alloc_branch_i), .alloc_tag_o(alloc_tag_o),
    .rob_full_o(rob_full_o), .rob_empty_o(rob_empty_o), .rob_count_o(rob_count_o),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .cdb_branch_i(cdb_branch_i), .cdb_branch_taken_i(cdb_branch_taken_i),
    .store_commit_ready_i(store_commit_ready_i),
    .commit_valid_o(commit_valid_o), .commit_tag_o(commit_tag_o), .commit_rd_o(commit_rd_o),
    .commit_data_o(commit_data_o), .commit_reg_write_o(commit_reg_write_o),
    .commit_store_o(commit_store_o), .flush_o(flush_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: program-ordered queue of in-flight instructions
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic        rw, st, br, done, tk;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          mtail;
  logic        e_cv, e_fl, e_crw, e_cst;
  logic [3:0]  e_ctag;
  logic [4:0]  e_crd;
  logic [31:0] e_cdata;

  function automatic void mclear();
    mq.delete();
    mtail = 0;
    e_cv = 0; e_fl = 0; e_crw = 0; e_cst = 0;
    e_ctag = 0; e_crd = 0; e_cdata = 0;
  endfunction

  function automatic void model_edge();
    bit   com = 0, fl = 0, acc;
    ent_t h, n;
    acc = alloc_en_i && (mq.size() < DEPTH);
    if (mq.size() > 0 && mq[0].done && (!mq[0].st || store_commit_ready_i)) begin
      com = 1;
      h   = mq[0];
      fl  = h.br && h.tk;
    end
    e_cv  = com;
    e_fl  = fl;
    e_crw = com && h.rw;
    e_cst = com && h.st;
    if (com) begin
      e_ctag = h.tag; e_crd = h.rd; e_cdata = h.data;
    end
    if (fl) begin
      mq.delete();
      mtail = 0;
    end else begin
      if (cdb_valid_i)
        foreach (mq[i])
          if (mq[i].tag == cdb_tag_i && !mq[i].done) begin
            mq[i].done = 1;
            mq[i].data = cdb_data_i;
            mq[i].tk   = cdb_branch_i && cdb_branch_taken_i;
          end
      if (com) void'(mq.pop_front());
      if (acc) begin
        n.tag = 4'(mtail); n.rd = alloc_rd_i; n.rw = alloc_reg_write_i;
        n.st = alloc_store_i; n.br = alloc_branch_i; n.done = 0; n.tk = 0; n.data = 0;
        mq.push_back(n);
        mtail = (mtail + 1) % DEPTH;
      end
    end
  endfunction

  task automatic cmp_model(input string nm);
    chk({nm, "_commit"},
        {19'd0, commit_valid_o, flush_o, commit_reg_write_o, commit_store_o,
         commit_tag_o, commit_rd_o, commit_data_o},
        {19'd0, e_cv, e_fl, e_crw, e_cst, e_ctag, e_crd, e_cdata});
    chk({nm, "_status"},
        {52'd0, rob_count_o, rob_full_o, rob_empty_o, alloc_tag_o},
        {52'd0, 5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, 4'(mtail)});
  endtask

  task automatic step(input string nm);
    @(posedge clk_i);
    #1;
    model_edge();
    cmp_model(nm);
  endtask

  task automatic set_idle();
    alloc_en_i = 0; alloc_rd_i = 0; alloc_reg_write_i = 0; alloc_store_i = 0; alloc_branch_i = 0;
    cdb_valid_i = 0; cdb_tag_i = 0; cdb_data_i = 0; cdb_branch_i = 0; cdb_branch_taken_i = 0;
    store_commit_ready_i = 1;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic rw, input logic st, input logic br);
    alloc_en_i = 1; alloc_rd_i = rd; alloc_reg_write_i = rw; alloc_store_i = st; alloc_branch_i = br;
  endtask

  task automatic do_cdb(input logic [3:0] tag, input logic [31:0] d, input logic br, input logic tk);
    cdb_valid_i = 1; cdb_tag_i = tag; cdb_data_i = d; cdb_branch_i = br; cdb_branch_taken_i = tk;
  endtask

  task automatic do_reset();
    set_idle();
    rst_ni = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1;
    mclear();
    cmp_model("rst");
  endtask

  typedef struct {
    logic        a_en;  logic [4:0] a_rd; logic a_rw, a_st, a_br;
    logic        c_v;   logic [3:0] c_tag; logic [31:0] c_data; logic c_br, c_tk;
    logic        e_cv;  logic [3:0] e_ctag; logic [31:0] e_cdata;
    logic [4:0]  e_cnt; logic [3:0] e_atag; logic e_fl;
  } vec_t;

  function automatic vec_t mk(logic a_en, logic [4:0] a_rd, logic a_rw, logic a_br,
                              logic c_v, logic [3:0] c_tag, logic [31:0] c_data, logic c_br, logic c_tk,
                              logic ecv, logic [3:0] ectag, logic [31:0] ecdata,
                              logic [4:0] ecnt, logic [3:0] eatag, logic efl);
    vec_t v;
    v.a_en = a_en; v.a_rd = a_rd; v.a_rw = a_rw; v.a_st = 0; v.a_br = a_br;
    v.c_v = c_v; v.c_tag = c_tag; v.c_data = c_data; v.c_br = c_br; v.c_tk = c_tk;
    v.e_cv = ecv; v.e_ctag = ectag; v.e_cdata = ecdata; v.e_cnt = ecnt; v.e_atag = eatag; v.e_fl = efl;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    set_idle();
    mclear();
    #2;
    chk("reset_async", {rob_count_o, rob_empty_o, rob_full_o, alloc_tag_o, commit_valid_o, flush_o},
        {5'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    do_reset();

    // Out-of-order completion, in-order retirement, then a taken-branch flush
    tbl[0]  = mk(1, 1, 1, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 1, 1, 0);
    tbl[1]  = mk(1, 2, 1, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 2, 2, 0);
    tbl[2]  = mk(1, 3, 1, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 3, 3, 0);
    tbl[3]  = mk(0, 0, 0, 0,  1, 2, 32'h22, 0, 0,  0, 0, 32'h00, 3, 3, 0);
    tbl[4]  = mk(0, 0, 0, 0,  1, 0, 32'h00, 0, 0,  0, 0, 32'h00, 3, 3, 0);
    tbl[5]  = mk(0, 0, 0, 0,  1, 1, 32'h11, 0, 0,  1, 0, 32'h00, 2, 3, 0);
    tbl[6]  = mk(0, 0, 0, 0,  0, 0, 32'h00, 0, 0,  1, 1, 32'h11, 1, 3, 0);
    tbl[7]  = mk(0, 0, 0, 0,  0, 0, 32'h00, 0, 0,  1, 2, 32'h22, 0, 3, 0);
    tbl[8]  = mk(1, 9, 1, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 1, 4, 0);
    tbl[9]  = mk(1, 0, 0, 1,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 2, 5, 0);
    tbl[10] = mk(1, 5, 1, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 3, 6, 0);
    tbl[11] = mk(1, 6, 1, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 4, 7, 0);
    tbl[12] = mk(0, 0, 0, 0,  1, 3, 32'h33, 0, 0,  0, 0, 32'h00, 4, 7, 0);
    tbl[13] = mk(0, 0, 0, 0,  1, 4, 32'h44, 1, 1,  1, 3, 32'h33, 3, 7, 0);
    tbl[14] = mk(0, 0, 0, 0,  1, 5, 32'h55, 0, 0,  1, 4, 32'h44, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0,  1, 5, 32'h55, 0, 0,  0, 0, 32'h00, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,  0, 0, 32'h00, 0, 0,  0, 0, 32'h00, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      alloc_en_i = tbl[i].a_en; alloc_rd_i = tbl[i].a_rd; alloc_reg_write_i = tbl[i].a_rw;
      alloc_store_i = tbl[i].a_st; alloc_branch_i = tbl[i].a_br;
      cdb_valid_i = tbl[i].c_v; cdb_tag_i = tbl[i].c_tag; cdb_data_i = tbl[i].c_data;
      cdb_branch_i = tbl[i].c_br; cdb_branch_taken_i = tbl[i].c_tk;
      store_commit_ready_i = 1;
      step("tbl_model");
      chk($sformatf("tbl%0d_cv", i), {63'd0, commit_valid_o}, {63'd0, tbl[i].e_cv});
      chk($sformatf("tbl%0d_flush", i), {63'd0, flush_o}, {63'd0, tbl[i].e_fl});
      chk($sformatf("tbl%0d_cnt_tag", i), {55'd0, rob_count_o, alloc_tag_o}, {55'd0, tbl[i].e_cnt, tbl[i].e_atag});
      if (tbl[i].e_cv)
        chk($sformatf("tbl%0d_commit", i), {28'd0, commit_tag_o, commit_data_o},
            {28'd0, tbl[i].e_ctag, tbl[i].e_cdata});
    end

    // Fill to full, reject the extra allocation, then wrap the tail
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_alloc(5'(i), 1, 0, 0);
      step("fill");
    end
    chk("full_set", {63'd0, rob_full_o}, 64'd1);
    step("fill_extra");
    chk("full_reject", {59'd0, rob_count_o}, 64'd16);
    do_cdb(0, 32'hA0, 0, 0);
    step("full_cdb");
    cdb_valid_i = 0;
    step("full_commit");
    chk("full_commit_cnt", {58'd0, commit_valid_o, rob_count_o}, {58'd0, 1'b1, 5'd15});
    chk("wrap_tag", {60'd0, alloc_tag_o}, 64'd0);
    step("wrap_alloc");
    chk("wrap_full", {58'd0, rob_full_o, rob_count_o}, {58'd0, 1'b1, 5'd16});

    // Stalled store at the head holds back completed younger entries
    do_reset();
    do_alloc(7, 0, 1, 0); step("st_alloc");
    do_alloc(8, 1, 0, 0); step("st_alloc");
    do_alloc(9, 1, 0, 0); step("st_alloc");
    alloc_en_i = 0;
    store_commit_ready_i = 0;
    do_cdb(1, 32'h101, 0, 0); step("st_cdb");
    do_cdb(2, 32'h102, 0, 0); step("st_cdb");
    do_cdb(0, 32'h100, 0, 0); step("st_cdb");
    cdb_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      step("st_hold");
      chk("st_stall", {58'd0, commit_valid_o, rob_count_o}, {58'd0, 1'b0, 5'd3});
    end
    store_commit_ready_i = 1;
    step("st_go");
    chk("st_commit", {58'd0, commit_valid_o, commit_store_o, commit_tag_o}, {58'd0, 1'b1, 1'b1, 4'd0});
    step("st_y1");
    chk("st_young1", {58'd0, commit_valid_o, commit_store_o, commit_tag_o}, {58'd0, 1'b1, 1'b0, 4'd1});
    step("st_y2");
    chk("st_young2", {58'd0, commit_valid_o, commit_tag_o}, {59'd0, 1'b1, 4'd2});

    // Not-taken branch retires without flush; duplicate CDB is ignored
    do_reset();
    do_alloc(0, 0, 0, 1); step("nt_alloc");
    do_alloc(4, 1, 0, 0); step("nt_alloc");
    alloc_en_i = 0;
    do_cdb(1, 32'h11, 0, 0); step("nt_cdb");
    do_cdb(1, 32'h99, 0, 0); step("nt_dup");
    do_cdb(0, 32'h0, 1, 0);  step("nt_br");
    cdb_valid_i = 0;
    step("nt_c0");
    chk("nt_noflush", {61'd0, commit_valid_o, flush_o, commit_tag_o == 4'd0}, {61'd0, 3'b101});
    step("nt_c1");
    chk("dup_data", {31'd0, commit_valid_o, commit_data_o}, {31'd0, 1'b1, 32'h11});

    // Asynchronous reset with entries pending
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_alloc(5'(i + 1), 1, 0, 0);
      step("ar_alloc");
    end
    set_idle();
    #2 rst_ni = 0;
    #1;
    chk("ar_clear", {57'd0, rob_count_o, rob_empty_o, commit_valid_o}, {57'd0, 5'd0, 1'b1, 1'b0});
    @(posedge clk_i);
    #3 rst_ni = 1;
    mclear();
    chk("ar_tag0", {60'd0, alloc_tag_o}, 64'd0);
    do_alloc(1, 1, 0, 0);
    step("ar_after");

    // Random traffic against the queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      alloc_en_i           = ($urandom_range(9) < 6);
      alloc_rd_i           = 5'($urandom);
      alloc_reg_write_i    = 1'($urandom);
      alloc_store_i        = ($urandom_range(3) == 0);
      alloc_branch_i       = ($urandom_range(3) == 0);
      store_commit_ready_i = ($urandom_range(9) < 7);
      cdb_valid_i          = ($urandom_range(9) < 6);
      cdb_data_i           = $urandom;
      cdb_branch_i         = 1'($urandom);
      cdb_branch_taken_i   = ($urandom_range(7) == 0);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        cdb_tag_i = mq[$urandom_range(mq.size() - 1)].tag;
      else
        cdb_tag_i = 4'($urandom);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
